// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: state encoding and occupancy constants
// reused by every stage in the pipeline.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      EMPTY:   occ_of = OCC_EMPTY;
      BUSY:    occ_of = OCC_BUSY;
      FULL:    occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; sticks at all-ones and only clears on reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage: full-throughput valid/ready register slice
// whose upstream ready comes straight from state flops.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             accept_s;
  logic             take_s;
  logic             stall_s;

  // Handshake flags are pure decodes of state, so in_ready never sees out_ready.
  assign in_ready  = (state_r != FULL);
  assign out_valid = (state_r != EMPTY);
  assign occupancy = occ_of(state_r);
  assign out_data  = main_r;
  assign accept_s  = in_valid & in_ready;
  assign take_s    = out_valid & out_ready;
  assign stall_s   = out_valid & ~out_ready;

  // State and payload registers; flush wins over every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else if (flush) begin
      state_r <= EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r <= BUSY;
            main_r  <= in_data;
          end
        end
        BUSY: begin
          if (accept_s && take_s) begin
            main_r <= in_data;
          end else if (accept_s) begin
            state_r <= FULL;
            skid_r  <= in_data;
          end else if (take_s) begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (take_s) begin
            state_r <= BUSY;
            main_r  <= skid_r;
          end
        end
        default: begin
          state_r <= EMPTY;
          main_r  <= '0;
          skid_r  <= '0;
        end
      endcase
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_s),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: two instances (8-bit/4-bit counter and
// 64-bit/16-bit counter) share control; a queue model of capacity 2 predicts outputs.
`timescale 1ns/1ps
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [7:0]  in_data8, out_data8;
  logic [63:0] in_data64, out_data64;
  logic        in_ready8, out_valid8, in_ready64, out_valid64;
  logic [1:0]  occ8, occ64;
  logic [3:0]  stall8;
  logic [15:0] stall64;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  q8[$];
  logic [63:0] q64[$];
  logic [7:0]  hold8;
  logic [63:0] hold64;
  int          exp_stall8, exp_stall64;
  int          pre_size;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .occupancy(occ8), .stall_cnt(stall8)
  );

  pipe_skid_stage #(.WIDTH(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
    .occupancy(occ64), .stall_cnt(stall64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    q8.delete();
    q64.delete();
    hold8       = 8'h00;
    hold64      = 64'h0;
    exp_stall8  = 0;
    exp_stall64 = 0;
  endtask

  // Monitor: compares outputs against the queue model mid-cycle and pops on take.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready8", 64'(in_ready8), 64'd1);
        chk("rst_out_valid8", 64'(out_valid8), 64'd0);
        chk("rst_occ8", 64'(occ8), 64'd0);
        chk("rst_out_data8", 64'(out_data8), 64'd0);
        chk("rst_out_data64", out_data64, 64'd0);
        chk("rst_stall8", 64'(stall8), 64'd0);
      end else begin
        pre_size = q8.size();
        chk("in_ready8", 64'(in_ready8), 64'(pre_size < 2));
        chk("in_ready64", 64'(in_ready64), 64'(pre_size < 2));
        chk("out_valid8", 64'(out_valid8), 64'(pre_size > 0));
        chk("out_valid64", 64'(out_valid64), 64'(pre_size > 0));
        chk("occupancy8", 64'(occ8), 64'(pre_size));
        chk("occupancy64", 64'(occ64), 64'(pre_size));
        chk("stall_cnt8", 64'(stall8), 64'(exp_stall8));
        chk("stall_cnt64", 64'(stall64), 64'(exp_stall64));
        if (pre_size > 0) begin
          chk("out_data8", 64'(out_data8), 64'(q8[0]));
          chk("out_data64", out_data64, q64[0]);
          if (out_ready) begin
            hold8  = q8.pop_front();
            hold64 = q64.pop_front();
          end
        end else begin
          chk("idle_data8", 64'(out_data8), 64'(hold8));
          chk("idle_data64", out_data64, hold64);
        end
        if (pre_size > 0 && !out_ready) begin
          if (exp_stall8 < 15) exp_stall8++;
          if (exp_stall64 < 65535) exp_stall64++;
        end
      end
    end
  end

  // One clock of stimulus; the offer is recorded once the monitor has seen the cycle.
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic [63:0] d);
    @(posedge clk); #1;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data8  = d[7:0];
    in_data64 = d;
    @(negedge clk); #2;
    if (fl) begin
      q8.delete();
      q64.delete();
      hold8  = 8'h00;
      hold64 = 64'h0;
    end else if (iv && pre_size < 2) begin
      q8.push_back(d[7:0]);
      q64.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic async_pulse();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("apulse_occ8", 64'(occ8), 64'd0);
    chk("apulse_out_valid8", 64'(out_valid8), 64'd0);
    chk("apulse_in_ready8", 64'(in_ready8), 64'd1);
    chk("apulse_out_data8", 64'(out_data8), 64'd0);
    chk("apulse_out_data64", out_data64, 64'd0);
    chk("apulse_stall8", 64'(stall8), 64'd0);
    clear_model();
    #1 rst = 1'b0;
    #0.5 chk("apulse_in_ready_after", 64'(in_ready8), 64'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data8 = 8'h00; in_data64 = 64'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // streaming at full rate
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 1'b0, 64'(i));
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // backpressure fills the skid slot, then drains in order
    cycle(1'b1, 1'b0, 1'b0, 64'hA);
    cycle(1'b1, 1'b0, 1'b0, 64'hB);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 64'hE);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // flush while full with a same-cycle offer
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 64'h1);
    cycle(1'b1, 1'b0, 1'b0, 64'h2);
    cycle(1'b1, 1'b0, 1'b1, 64'hC);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // stall counter saturation survives flush, cleared by reset
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 64'h5);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 64'h0);
    chk("sat_stall8", 64'(stall8), 64'd15);
    cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    chk("sat_after_flush", 64'(stall8), 64'd15);
    do_reset();
    chk("sat_after_rst", 64'(stall8), 64'd0);

    // asynchronous reset pulse while full
    cycle(1'b1, 1'b0, 1'b0, 64'h7);
    cycle(1'b1, 1'b0, 1'b0, 64'h8);
    async_pulse();
    cycle(1'b1, 1'b1, 1'b0, 64'h9);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 63) == 0, {$urandom(), $urandom()});
      end
    end
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload bit width (1..256).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width (4..32).
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: flush  input  1  synchronous kill of all stage contents.
REQ-006 Port: in_valid  input  1  upstream payload offered.
REQ-007 Port: in_ready  output  1  stage can accept this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  stage presents payload downstream.
REQ-010 Port: out_ready  input  1  downstream accepts this cycle.
REQ-011 Port: out_data  output  WIDTH  payload presented downstream.
REQ-012 Port: occupancy  output  2  entries held (0, 1 or 2).
REQ-013 Port: stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Transfers SHALL occur only on edges where valid and ready are both 1 on that side ("accept" upstream, "take" downstream).
REQ-015 The stage SHALL hold a main register (drives out_data) and one skid register; states EMPTY (0 entries), BUSY (main valid), FULL (main+skid valid).
REQ-016 in_ready SHALL equal (state != FULL) and SHALL be decoded from state registers only, with no combinational path from out_ready, in_valid or flush.
REQ-017 out_valid SHALL equal (state != EMPTY); occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-018 EMPTY: accept -> BUSY, main<=in_data; else stay.
REQ-019 BUSY: accept and take -> BUSY, main<=in_data; accept only -> FULL, skid<=in_data; take only -> EMPTY; neither -> stay.
REQ-020 FULL: take -> BUSY, main<=skid; no accept possible; else stay.
REQ-021 Latency in_data to out_data SHALL be exactly 1 cycle from EMPTY; sustained throughput SHALL be one payload per cycle with out_ready held 1.
REQ-022 out_data SHALL remain bit-stable while out_valid=1 and out_ready=0; payload order SHALL be strictly FIFO; no payload duplicated or lost except by flush.
REQ-023 flush SHALL have priority over every transition: next state EMPTY, main and skid cleared to zero, any same-cycle upstream offer discarded.
REQ-024 A take coinciding with flush SHALL count as a completed transfer (downstream may consume it).
REQ-025 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and not be cleared by flush.
REQ-026 Registers not being loaded SHALL hold their value exactly (no side arithmetic on held payload).

Reset
REQ-027 While rst=1: state EMPTY, main=0, skid=0, stall_cnt=0; hence out_valid=0, out_data=0, occupancy=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); first accept possible on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the state encoding type (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and occupancy constants, reused by later pipeline stages.
REQ-030 The saturating stall counter SHALL be a sub-module pipe_sat_counter (parameter CNT_W, inputs clk, rst, inc; output count); all other logic stays in pipe_skid_stage.

Verification
REQ-031 Stream: out_ready=1, in_valid=1 with in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1, stall_cnt=0.
REQ-032 Backpressure: load 0xA then 0xB while out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held; release out_ready -> 0xA then 0xB out, stall_cnt equals stalled cycles.
REQ-033 Flush in FULL with in_valid=1 in_data=0xC -> next cycle occupancy=0, out_valid=0, out_data=0, 0xC never appears downstream.
REQ-034 Saturation: CNT_W=4, out_ready=0 with one entry for 20 cycles -> stall_cnt stops at 15; flush does not clear it; rst does.
REQ-035 Async reset pulse between edges while FULL -> outputs reach reset values before next edge; in_ready=1 after release.
REQ-036 Random valid/ready (≥10k cycles, WIDTH=8 and 64) against scoreboard -> zero order/loss/duplication errors, in_ready never depends on same-cycle out_ready.
